bp_be_late_wb_buffer: RTL and testbench
=======================================

# bp_be_late_wb_buffer

Consumes the D$ late-load writeback stream produced by the memory pipe (late rd address, float flag, data) and buffers it in a small in-order queue. It drives the late integer and late float register-file write requests toward the scheduler's writeback arbitration. It also exports per-register pending masks so hazard detection can stall consumers of an in-flight late load.

## Interface
Parameters:
- els_p, 4, queue depth; power of two, ≥2
- data_width_p, dpath_width_gp (66), writeback data width
- reg_addr_width_p, reg_addr_width_gp (5), register address width

Ports:
- clk_i  in  1  clock; all state updates on posedge
- reset_n_i  in  1  reset; **asynchronous, active-low**
- late_v_i  in  1  late load result valid
- late_float_i  in  1  1 = float destination, 0 = integer
- late_rd_addr_i  in  reg_addr_width_p  destination register
- late_data_i  in  data_width_p  load data
- late_yumi_o  out  1  input accepted this cycle
- iwb_v_o  out  1  head entry is integer
- iwb_rd_addr_o  out  reg_addr_width_p  integer destination
- iwb_data_o  out  data_width_p  integer data
- iwb_yumi_i  in  1  integer write performed
- fwb_v_o  out  1  head entry is float
- fwb_rd_addr_o  out  reg_addr_width_p  float destination
- fwb_data_o  out  data_width_p  float data
- fwb_yumi_i  in  1  float write performed
- ipend_o  out  2**reg_addr_width_p  integer registers with a queued late write
- fpend_o  out  2**reg_addr_width_p  float registers with a queued late write
- empty_o  out  1  no valid entries

## Operation
- Circular FIFO: wptr, rptr (log2(els_p) bits, wrap modulo els_p), count (log2(els_p)+1 bits, 0..els_p).
- Enqueue: late_yumi_o = late_v_i & (count != els_p). Full blocks enqueue even when a dequeue occurs in the same cycle; this avoids a yumi→yumi combinational path.
- Integer rd = x0: accepted (late_yumi_o = 1) but not stored; count and pointers unchanged.
- Head presentation: iwb_v_o = ~empty & ~head.float; fwb_v_o = ~empty & head.float. At most one is high.
- Dequeue when (iwb_v_o & iwb_yumi_i) | (fwb_v_o & fwb_yumi_i). A yumi without the matching v is a protocol error; it is ignored, and the bench asserts it never occurs.
- Simultaneous enqueue and dequeue (count not full): count unchanged, both pointers advance.
- Pending masks: the OR over valid entries of one-hot(rd_addr), split by float flag. Duplicate addresses keep the bit set until the last matching entry retires.
- No flush input. Late writebacks are committed state and survive pipeline flush.
- Reset (async assert): count = 0, wptr = rptr = 0. Data storage is not reset. All outputs then read: iwb_v_o = fwb_v_o = 0, ipend_o = fpend_o = 0, empty_o = 1, late_yumi_o = 0. Reset mid-operation drops all queued entries.

## Timing
- Without bypass: late_v_i accepted in cycle N; the entry is visible at the head, and in the pending masks, in cycle N+1.
- Head outputs and pending masks are functions of registered state only.
- late_yumi_o depends combinationally on late_v_i and registered count only.
- Dequeue on posedge after yumi. The next entry is presented in the following cycle.
- Sustained throughput: 1 entry/cycle when not full.

## Configuration
- BP_BE_LATE_WB_BYPASS_EN defined:
  - When empty and late_v_i (non-x0 integer, or float), the input drives iwb/fwb outputs in the same cycle.
  - If the matching yumi is asserted, the entry is consumed without being stored.
  - Otherwise it is enqueued as normal.
  - ipend_o/fpend_o also OR in the bypassing entry.
- Not defined: strictly registered, 1-cycle minimum latency as above.

## Structure
- bp_be_pkg holds:
  - bp_be_late_wb_entry_s {float, rd_addr, data}
  - width macro `bp_be_late_wb_entry_width(data_width_p)
- One sub-module, bp_be_late_wb_fifo: pointer/count control plus a storage array of els_p entries, exposing per-entry valid and the entry array. The top computes head routing and pending masks.

## Test plan
- Reset then idle: with reset_n_i low, all v outputs and masks read 0 and empty_o = 1. After release, an int load to x5 with data 0x1234 → iwb_v_o = 1 next cycle, rd 5, data 0x1234, ipend_o[5] = 1. Yumi → empty_o = 1 and ipend_o = 0 the following cycle.
- Fill to 4 with no yumi (int x1, float f2, int x3, float f4) → 5th late_v_i gets late_yumi_o = 0, ipend_o = 0x0A, fpend_o = 0x14. Then drain with yumi each cycle → outputs in order iwb, fwb, iwb, fwb.
- Full plus simultaneous dequeue: count = 4, late_v_i = 1, iwb_yumi_i = 1 → late_yumi_o = 0, count = 3 next cycle. Next cycle with both valid → count stays 3 and pointers wrap correctly.
- x0 discard: int rd 0 → late_yumi_o = 1, empty_o stays 1, ipend_o[0] stays 0. Float f0 → stored, fpend_o[0] = 1.
- Duplicate destination: two loads to x7 queued; first retires → ipend_o[7] still 1; second retires → 0.
- Async reset mid-operation with 3 entries queued: drop reset_n_i between edges → v outputs fall immediately, count = 0. With BP_BE_LATE_WB_BYPASS_EN, an empty queue plus late_v_i and iwb_yumi_i in the same cycle → no enqueue, empty_o stays 1.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared backend types for the late-load writeback buffer: default widths,
// the queue entry layout and a width helper macro.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

package bp_be_pkg;

    localparam int dpath_width_gp    = 66;
    localparam int reg_addr_width_gp = 5;

    typedef struct packed {
        logic                         float;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dpath_width_gp-1:0]    data;
    } bp_be_late_wb_entry_s;

endpackage

// Packed entry width for a given data width at the default register address width.
`define BP_BE_LATE_WB_ENTRY_WIDTH(data_width_mp) (1 + bp_be_pkg::reg_addr_width_gp + (data_width_mp))

`endif

// File: rtl/bp_be_late_wb_fifo.sv
// In-order circular queue for late writebacks: pointer/count control plus an
// unreset storage array, exposing per-entry valid bits and the raw entries.
module bp_be_late_wb_fifo
    import bp_be_pkg::*;
#(
    parameter int els_p         = 4,
    parameter int entry_width_p = `BP_BE_LATE_WB_ENTRY_WIDTH(dpath_width_gp),
    localparam int ptr_width_lp = $clog2(els_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                enq_i,
    input  logic [entry_width_p-1:0]            enq_data_i,
    input  logic                                deq_i,
    output logic [els_p-1:0]                    valid_o,
    output logic [els_p-1:0][entry_width_p-1:0] entries_o,
    output logic [ptr_width_lp-1:0]             rptr_o,
    output logic [ptr_width_lp:0]               count_o
);

    logic [ptr_width_lp-1:0]             wptr_r;
    logic [ptr_width_lp-1:0]             rptr_r;
    logic [ptr_width_lp:0]               count_r;
    logic [els_p-1:0][entry_width_p-1:0] mem_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq_i) wptr_r <= wptr_r + 1'b1;
            if (deq_i) rptr_r <= rptr_r + 1'b1;
            if (enq_i && !deq_i)
                count_r <= count_r + 1'b1;
            else if (deq_i && !enq_i)
                count_r <= count_r - 1'b1;
        end
    end

    // NOTE: storage has no reset; validity comes solely from count/rptr, so stale data is never observed.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_r[wptr_r] <= enq_data_i;
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < els_p; i++) begin
            valid_o[i] = {1'b0, ptr_width_lp'(i) - rptr_r} < count_r;
        end
    end

    assign entries_o = mem_r;
    assign rptr_o    = rptr_r;
    assign count_o   = count_r;

endmodule

// File: rtl/bp_be_late_wb_buffer.sv
// Late-load writeback buffer: queues D$ late results and presents them to the
// int/float writeback ports with pending-register masks. Option: BP_BE_LATE_WB_BYPASS_EN.
module bp_be_late_wb_buffer
    import bp_be_pkg::*;
#(
    parameter int els_p            = 4,
    parameter int data_width_p     = dpath_width_gp,
    parameter int reg_addr_width_p = reg_addr_width_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           late_v_i,
    input  logic                           late_float_i,
    input  logic [reg_addr_width_p-1:0]    late_rd_addr_i,
    input  logic [data_width_p-1:0]        late_data_i,
    output logic                           late_yumi_o,
    output logic                           iwb_v_o,
    output logic [reg_addr_width_p-1:0]    iwb_rd_addr_o,
    output logic [data_width_p-1:0]        iwb_data_o,
    input  logic                           iwb_yumi_i,
    output logic                           fwb_v_o,
    output logic [reg_addr_width_p-1:0]    fwb_rd_addr_o,
    output logic [data_width_p-1:0]        fwb_data_o,
    input  logic                           fwb_yumi_i,
    output logic [2**reg_addr_width_p-1:0] ipend_o,
    output logic [2**reg_addr_width_p-1:0] fpend_o,
    output logic                           empty_o
);

    localparam int ptr_width_lp = $clog2(els_p);

    typedef struct packed {
        logic                        float;
        logic [reg_addr_width_p-1:0] rd_addr;
        logic [data_width_p-1:0]     data;
    } entry_s;

    localparam int entry_width_lp = $bits(entry_s);

    entry_s                               enq_entry;
    entry_s                               head;
    entry_s                               out_entry;
    entry_s                               pend_entry;
    logic [els_p-1:0]                     entry_v;
    logic [els_p-1:0][entry_width_lp-1:0] entries;
    logic [ptr_width_lp-1:0]              rptr;
    logic [ptr_width_lp:0]                count;
    logic                                 full;
    logic                                 queue_empty;
    logic                                 late_x0;
    logic                                 enq;
    logic                                 deq;
    logic                                 out_v;

    bp_be_late_wb_fifo #(
        .els_p        (els_p),
        .entry_width_p(entry_width_lp)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (enq),
        .enq_data_i(enq_entry),
        .deq_i     (deq),
        .valid_o   (entry_v),
        .entries_o (entries),
        .rptr_o    (rptr),
        .count_o   (count)
    );

    assign full        = (count == (ptr_width_lp + 1)'(els_p));
    assign queue_empty = (count == '0);
    // Integer x0 writes are architecturally dead: acknowledge them and drop them.
    assign late_x0     = ~late_float_i & (late_rd_addr_i == '0);
    // Full blocks enqueue even if the head retires this cycle, keeping yumi_i off the yumi_o path.
    assign late_yumi_o = late_v_i & ~full;

    assign enq_entry = '{float: late_float_i, rd_addr: late_rd_addr_i, data: late_data_i};
    assign head      = entry_s'(entries[rptr]);
    assign deq       = ~queue_empty & (head.float ? fwb_yumi_i : iwb_yumi_i);

`ifdef BP_BE_LATE_WB_BYPASS_EN
    logic bypass_v;
    logic bypass_taken;

    assign bypass_v     = queue_empty & late_v_i & ~late_x0;
    assign bypass_taken = bypass_v & (late_float_i ? fwb_yumi_i : iwb_yumi_i);
    assign out_v        = ~queue_empty | bypass_v;
    assign out_entry    = queue_empty ? enq_entry : head;
    assign enq          = late_yumi_o & ~late_x0 & ~bypass_taken;
`else
    assign out_v     = ~queue_empty;
    assign out_entry = head;
    assign enq       = late_yumi_o & ~late_x0;
`endif

    assign iwb_v_o       = out_v & ~out_entry.float;
    assign fwb_v_o       = out_v &  out_entry.float;
    assign iwb_rd_addr_o = out_entry.rd_addr;
    assign iwb_data_o    = out_entry.data;
    assign fwb_rd_addr_o = out_entry.rd_addr;
    assign fwb_data_o    = out_entry.data;
    assign empty_o       = queue_empty;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        ipend_o    = '0;
        fpend_o    = '0;
        pend_entry = '0;
        for (int i = 0; i < els_p; i++) begin
            if (entry_v[i]) begin
                pend_entry = entry_s'(entries[i]);
                if (pend_entry.float) fpend_o[pend_entry.rd_addr] = 1'b1;
                else                  ipend_o[pend_entry.rd_addr] = 1'b1;
            end
        end
`ifdef BP_BE_LATE_WB_BYPASS_EN
        if (bypass_v) begin
            if (late_float_i) fpend_o[late_rd_addr_i] = 1'b1;
            else              ipend_o[late_rd_addr_i] = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
// Directed self-checking bench for bp_be_late_wb_buffer (default build; bypass
// scenario included when BP_BE_LATE_WB_BYPASS_EN is defined).
module tb_bp_be_late_wb_buffer;

    localparam int data_w = 66;
    localparam int addr_w = 5;
    localparam int regs   = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              late_v;
    logic              late_float;
    logic [addr_w-1:0] late_rd_addr;
    logic [data_w-1:0] late_data;
    logic              late_yumi;
    logic              iwb_v;
    logic [addr_w-1:0] iwb_rd_addr;
    logic [data_w-1:0] iwb_data;
    logic              iwb_yumi;
    logic              fwb_v;
    logic [addr_w-1:0] fwb_rd_addr;
    logic [data_w-1:0] fwb_data;
    logic              fwb_yumi;
    logic [regs-1:0]   ipend;
    logic [regs-1:0]   fpend;
    logic              empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_be_late_wb_buffer dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .late_v_i      (late_v),
        .late_float_i  (late_float),
        .late_rd_addr_i(late_rd_addr),
        .late_data_i   (late_data),
        .late_yumi_o   (late_yumi),
        .iwb_v_o       (iwb_v),
        .iwb_rd_addr_o (iwb_rd_addr),
        .iwb_data_o    (iwb_data),
        .iwb_yumi_i    (iwb_yumi),
        .fwb_v_o       (fwb_v),
        .fwb_rd_addr_o (fwb_rd_addr),
        .fwb_data_o    (fwb_data),
        .fwb_yumi_i    (fwb_yumi),
        .ipend_o       (ipend),
        .fpend_o       (fpend),
        .empty_o       (empty)
    );

    // A yumi must only ever accompany its matching valid.
    always @(posedge clk) begin
        if (reset_n && ((iwb_yumi && !iwb_v) || (fwb_yumi && !fwb_v))) begin
            errors++;
            $display("FAIL protocol: iwb_yumi=%0b iwb_v=%0b fwb_yumi=%0b fwb_v=%0b", iwb_yumi, iwb_v, fwb_yumi, fwb_v);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        late_v       = 1'b0;
        late_float   = 1'b0;
        late_rd_addr = '0;
        late_data    = '0;
        iwb_yumi     = 1'b0;
        fwb_yumi     = 1'b0;
    endtask

    task automatic set_late(input logic f, input logic [addr_w-1:0] rd, input logic [data_w-1:0] d);
        late_v       = 1'b1;
        late_float   = f;
        late_rd_addr = rd;
        late_data    = d;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #3;
        checks++; if (iwb_v !== 1'b0 || fwb_v !== 1'b0) begin errors++; $display("FAIL reset_v: iwb_v=%0b fwb_v=%0b expected 0 0", iwb_v, fwb_v); end
        checks++; if (ipend !== '0 || fpend !== '0) begin errors++; $display("FAIL reset_pend: ipend=%h fpend=%h expected 0 0", ipend, fpend); end
        checks++; if (empty !== 1'b1 || late_yumi !== 1'b0) begin errors++; $display("FAIL reset_empty: empty=%0b late_yumi=%0b expected 1 0", empty, late_yumi); end
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_basic();
        set_late(1'b0, 5'd5, 66'h1234);
        #1;
        checks++; if (late_yumi !== 1'b1) begin errors++; $display("FAIL basic_yumi: got %0b expected 1", late_yumi); end
        cyc();
        idle();
        #1;
        checks++; if (iwb_v !== 1'b1 || fwb_v !== 1'b0 || iwb_rd_addr !== 5'd5 || iwb_data !== 66'h1234)
            begin errors++; $display("FAIL basic_head: iwb_v=%0b fwb_v=%0b rd=%0d data=%h expected 1 0 5 1234", iwb_v, fwb_v, iwb_rd_addr, iwb_data); end
        checks++; if (ipend !== 32'h0000_0020 || fpend !== '0 || empty !== 1'b0)
            begin errors++; $display("FAIL basic_pend: ipend=%h fpend=%h empty=%0b expected 00000020 0 0", ipend, fpend, empty); end
        iwb_yumi = 1'b1;
        cyc();
        iwb_yumi = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || ipend !== '0 || iwb_v !== 1'b0)
            begin errors++; $display("FAIL basic_retire: empty=%0b ipend=%h iwb_v=%0b expected 1 0 0", empty, ipend, iwb_v); end
    endtask

    // Drain n entries in order, one retirement per cycle, checking each head.
    task automatic drain(input int n, input logic fl [4], input logic [addr_w-1:0] rds [4], input logic [data_w-1:0] ds [4], input string tag);
        for (int i = 0; i < n; i++) begin
            logic v_ok;
            v_ok = fl[i] ? (fwb_v === 1'b1 && iwb_v === 1'b0 && fwb_rd_addr === rds[i] && fwb_data === ds[i])
                         : (iwb_v === 1'b1 && fwb_v === 1'b0 && iwb_rd_addr === rds[i] && iwb_data === ds[i]);
            checks++; if (!v_ok)
                begin errors++; $display("FAIL %s_head%0d: iwb_v=%0b fwb_v=%0b irs=%0d frd=%0d idata=%h fdata=%h expected float=%0b rd=%0d data=%h",
                                         tag, i, iwb_v, fwb_v, iwb_rd_addr, fwb_rd_addr, iwb_data, fwb_data, fl[i], rds[i], ds[i]); end
            iwb_yumi = iwb_v & ~fl[i];
            fwb_yumi = fwb_v &  fl[i];
            cyc();
            iwb_yumi = 1'b0;
            fwb_yumi = 1'b0;
        end
        #1;
        checks++; if (empty !== 1'b1 || ipend !== '0 || fpend !== '0)
            begin errors++; $display("FAIL %s_drained: empty=%0b ipend=%h fpend=%h expected 1 0 0", tag, empty, ipend, fpend); end
    endtask

    task automatic test_fill();
        logic              fl  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [addr_w-1:0] rds [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
        logic [data_w-1:0] ds  [4] = '{66'h11, 66'h22, 66'h33, 66'h44};
        for (int i = 0; i < 4; i++) begin
            set_late(fl[i], rds[i], ds[i]);
            cyc();
        end
        set_late(1'b0, 5'd9, 66'h99);
        #1;
        checks++; if (late_yumi !== 1'b0) begin errors++; $display("FAIL fill_full_yumi: got %0b expected 0", late_yumi); end
        checks++; if (ipend !== 32'h0000_000A || fpend !== 32'h0000_0014)
            begin errors++; $display("FAIL fill_pend: ipend=%h fpend=%h expected 0000000a 00000014", ipend, fpend); end
        idle();
        #1;
        drain(4, fl, rds, ds, "fill");
    endtask

    task automatic test_full_deq();
        logic              fl  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [addr_w-1:0] rds [4] = '{5'd3, 5'd4, 5'd5, 5'd0};
        logic [data_w-1:0] ds  [4] = '{66'h103, 66'h104, 66'h105, 66'h0};
        for (int i = 1; i <= 4; i++) begin
            set_late(1'b0, addr_w'(i), data_w'(32'h100 + i));
            cyc();
        end
        set_late(1'b0, 5'd5, 66'h105);
        iwb_yumi = 1'b1;
        #1;
        checks++; if (late_yumi !== 1'b0) begin errors++; $display("FAIL fulldeq_yumi_full: got %0b expected 0", late_yumi); end
        cyc();
        checks++; if (ipend !== 32'h0000_001C || late_yumi !== 1'b1 || iwb_rd_addr !== 5'd2 || iwb_data !== 66'h102)
            begin errors++; $display("FAIL fulldeq_count3: ipend=%h late_yumi=%0b rd=%0d data=%h expected 0000001c 1 2 102", ipend, late_yumi, iwb_rd_addr, iwb_data); end
        cyc();
        idle();
        #1;
        checks++; if (ipend !== 32'h0000_0038 || iwb_v !== 1'b1 || empty !== 1'b0)
            begin errors++; $display("FAIL fulldeq_steady: ipend=%h iwb_v=%0b empty=%0b expected 00000038 1 0", ipend, iwb_v, empty); end
        drain(3, fl, rds, ds, "fulldeq");
    endtask

    task automatic test_x0();
        set_late(1'b0, 5'd0, 66'hDEAD);
        #1;
        checks++; if (late_yumi !== 1'b1) begin errors++; $display("FAIL x0_yumi: got %0b expected 1", late_yumi); end
        cyc();
        idle();
        #1;
        checks++; if (empty !== 1'b1 || ipend !== '0 || iwb_v !== 1'b0)
            begin errors++; $display("FAIL x0_discard: empty=%0b ipend=%h iwb_v=%0b expected 1 0 0", empty, ipend, iwb_v); end
        set_late(1'b1, 5'd0, 66'hF0);
        cyc();
        idle();
        #1;
        checks++; if (fwb_v !== 1'b1 || iwb_v !== 1'b0 || fwb_rd_addr !== 5'd0 || fwb_data !== 66'hF0 || fpend !== 32'h1)
            begin errors++; $display("FAIL f0_stored: fwb_v=%0b iwb_v=%0b rd=%0d data=%h fpend=%h expected 1 0 0 f0 00000001", fwb_v, iwb_v, fwb_rd_addr, fwb_data, fpend); end
        fwb_yumi = 1'b1;
        cyc();
        fwb_yumi = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || fpend !== '0)
            begin errors++; $display("FAIL f0_retire: empty=%0b fpend=%h expected 1 0", empty, fpend); end
    endtask

    task automatic test_dup();
        set_late(1'b0, 5'd7, 66'h71);
        cyc();
        set_late(1'b0, 5'd7, 66'h72);
        cyc();
        idle();
        #1;
        checks++; if (ipend !== 32'h0000_0080) begin errors++; $display("FAIL dup_both: ipend=%h expected 00000080", ipend); end
        iwb_yumi = 1'b1;
        cyc();
        iwb_yumi = 1'b0;
        #1;
        checks++; if (ipend !== 32'h0000_0080 || iwb_data !== 66'h72)
            begin errors++; $display("FAIL dup_first_retired: ipend=%h data=%h expected 00000080 72", ipend, iwb_data); end
        iwb_yumi = 1'b1;
        cyc();
        iwb_yumi = 1'b0;
        #1;
        checks++; if (ipend !== '0 || empty !== 1'b1)
            begin errors++; $display("FAIL dup_second_retired: ipend=%h empty=%0b expected 0 1", ipend, empty); end
    endtask

    task automatic test_async_reset();
        set_late(1'b0, 5'd1, 66'hA1);
        cyc();
        set_late(1'b1, 5'd2, 66'hA2);
        cyc();
        set_late(1'b0, 5'd3, 66'hA3);
        cyc();
        idle();
        #1;
        checks++; if (iwb_v !== 1'b1 || ipend !== 32'h0000_000A || fpend !== 32'h0000_0004)
            begin errors++; $display("FAIL arst_pre: iwb_v=%0b ipend=%h fpend=%h expected 1 0000000a 00000004", iwb_v, ipend, fpend); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (iwb_v !== 1'b0 || fwb_v !== 1'b0 || empty !== 1'b1 || ipend !== '0 || fpend !== '0)
            begin errors++; $display("FAIL arst_async: iwb_v=%0b fwb_v=%0b empty=%0b ipend=%h fpend=%h expected 0 0 1 0 0", iwb_v, fwb_v, empty, ipend, fpend); end
        #1 reset_n = 1'b1;
        cyc();
        checks++; if (empty !== 1'b1 || iwb_v !== 1'b0)
            begin errors++; $display("FAIL arst_dropped: empty=%0b iwb_v=%0b expected 1 0", empty, iwb_v); end
        set_late(1'b0, 5'd9, 66'h99);
        cyc();
        idle();
        #1;
        checks++; if (iwb_v !== 1'b1 || iwb_rd_addr !== 5'd9 || iwb_data !== 66'h99 || ipend !== 32'h0000_0200)
            begin errors++; $display("FAIL arst_resume: iwb_v=%0b rd=%0d data=%h ipend=%h expected 1 9 99 00000200", iwb_v, iwb_rd_addr, iwb_data, ipend); end
        iwb_yumi = 1'b1;
        cyc();
        iwb_yumi = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_resume_drain: empty=%0b expected 1", empty); end
    endtask

`ifdef BP_BE_LATE_WB_BYPASS_EN
    task automatic test_bypass();
        set_late(1'b0, 5'd6, 66'h66);
        iwb_yumi = 1'b1;
        #1;
        checks++; if (iwb_v !== 1'b1 || iwb_rd_addr !== 5'd6 || iwb_data !== 66'h66 || ipend !== 32'h0000_0040)
            begin errors++; $display("FAIL bypass_same_cycle: iwb_v=%0b rd=%0d data=%h ipend=%h expected 1 6 66 00000040", iwb_v, iwb_rd_addr, iwb_data, ipend); end
        cyc();
        idle();
        #1;
        checks++; if (empty !== 1'b1 || iwb_v !== 1'b0 || ipend !== '0)
            begin errors++; $display("FAIL bypass_consumed: empty=%0b iwb_v=%0b ipend=%h expected 1 0 0", empty, iwb_v, ipend); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_full_deq();
        test_x0();
        test_dup();
        test_async_reset();
`ifdef BP_BE_LATE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
